// File: rtl/fma_dot_sequencer_if.sv
// Bundle between the dot-product sequencer, its operand/result clients and the shared FMA unit.
// The sequencer uses the slave modport; the surrounding environment uses master.
interface fma_dot_sequencer_if #(
  parameter int FMA_LAT = 3,
  parameter int LEN_W   = 8
);
  localparam int S     = FMA_LAT + 1;
  localparam int TAG_W = (S > 1) ? $clog2(S) : 1;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             fma_valid;
  logic [31:0]      fma_f0;
  logic [31:0]      fma_f1;
  logic [31:0]      fma_acc;
  logic [TAG_W-1:0] fma_tag;
  logic             fma_res_valid;
  logic [31:0]      fma_res;
  logic [TAG_W-1:0] fma_res_tag;
  logic             fma_inf;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res;
  logic             res_inf;

  modport slave (
    input  start, len, in_valid, in_a, in_b,
    input  fma_res_valid, fma_res, fma_res_tag, fma_inf, res_ready,
    output busy, in_ready, fma_valid, fma_f0, fma_f1, fma_acc, fma_tag,
    output res_valid, res, res_inf
  );

  modport master (
    output start, len, in_valid, in_a, in_b,
    output fma_res_valid, fma_res, fma_res_tag, fma_inf, res_ready,
    input  busy, in_ready, fma_valid, fma_f0, fma_f1, fma_acc, fma_tag,
    input  res_valid, res, res_inf
  );
endinterface

// File: rtl/fma_dot_sequencer.sv
// Length-K dot product on one shared pipelined FMA using FMA_LAT+1 rotating partial sums.
// Optional sticky infinity flag: define FMA_SEQ_STICKY_INF_EN.
module fma_dot_sequencer #(
  parameter int FMA_LAT = 3,
  parameter int LEN_W   = 8
) (
  input logic                clk,
  input logic                rst_n,
  fma_dot_sequencer_if.slave bus
);
  localparam int S     = FMA_LAT + 1;
  localparam int TAG_W = (S > 1) ? $clog2(S) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_REDUCE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  logic [2:0]         state_q, state_d;
  logic [S-1:0][31:0] part_q, part_d;
  logic [S-1:0]       infl_q, infl_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [TAG_W-1:0]   j_q, j_d;
  logic               wait_q, wait_d;
  logic [31:0]        total_q, total_d;
  logic               busy_q, busy_d;
  logic               fv_q, fv_d;
  logic [31:0]        f0_q, f0_d;
  logic [31:0]        f1_q, f1_d;
  logic [31:0]        acc_q, acc_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               rv_q, rv_d;
  logic [31:0]        res_q, res_d;
  logic               in_ready_s;

  // A slot only accepts a new operand once its previous result has come back.
  assign in_ready_s = (state_q == ST_ISSUE) && !infl_q[ptr_q];

  // Next-state and datapath-request logic.
  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    infl_d  = infl_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    j_d     = j_q;
    wait_d  = wait_q;
    total_d = total_q;
    busy_d  = busy_q;
    fv_d    = 1'b0;
    f0_d    = f0_q;
    f1_d    = f1_q;
    acc_d   = acc_q;
    tag_d   = tag_q;
    rv_d    = rv_q;
    res_d   = res_q;

    if (bus.fma_res_valid) begin
      part_d[bus.fma_res_tag] = bus.fma_res;
      infl_d[bus.fma_res_tag] = 1'b0;
    end else begin
      part_d = part_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          part_d = '0;
          infl_d = '0;
          cnt_d  = '0;
          ptr_d  = '0;
          len_d  = bus.len;
          busy_d = 1'b1;
          if (bus.len == '0) begin
            state_d = ST_DONE;
            rv_d    = 1'b1;
            res_d   = 32'h0000_0000;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.in_valid && in_ready_s) begin
          fv_d          = 1'b1;
          f0_d          = bus.in_a;
          f1_d          = bus.in_b;
          acc_d         = part_q[ptr_q];
          tag_d         = ptr_q;
          infl_d[ptr_q] = 1'b1;
          ptr_d         = (ptr_q == TAG_W'(S - 1)) ? '0 : ptr_q + TAG_W'(1);
          cnt_d         = cnt_q + LEN_W'(1);
          if ((cnt_q + LEN_W'(1)) == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (infl_q == '0) begin
          state_d = ST_REDUCE;
          total_d = part_q[0];
          j_d     = TAG_W'(1);
          wait_d  = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REDUCE: begin
        // Serial fold: total = partial[j] * 1.0 + total, one round trip per slot.
        if (!wait_q) begin
          fv_d   = 1'b1;
          f0_d   = part_q[j_q];
          f1_d   = FP_ONE;
          acc_d  = total_q;
          tag_d  = '0;
          wait_d = 1'b1;
        end else if (bus.fma_res_valid) begin
          total_d = bus.fma_res;
          wait_d  = 1'b0;
          if (j_q == TAG_W'(S - 1)) begin
            state_d = ST_DONE;
            rv_d    = 1'b1;
            res_d   = bus.fma_res;
          end else begin
            j_d = j_q + TAG_W'(1);
          end
        end else begin
          wait_d = wait_q;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      part_q  <= '0;
      infl_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      j_q     <= '0;
      wait_q  <= 1'b0;
      total_q <= 32'h0000_0000;
      busy_q  <= 1'b0;
      fv_q    <= 1'b0;
      f0_q    <= 32'h0000_0000;
      f1_q    <= 32'h0000_0000;
      acc_q   <= 32'h0000_0000;
      tag_q   <= '0;
      rv_q    <= 1'b0;
      res_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      j_q     <= j_d;
      wait_q  <= wait_d;
      total_q <= total_d;
      busy_q  <= busy_d;
      fv_q    <= fv_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      acc_q   <= acc_d;
      tag_q   <= tag_d;
      rv_q    <= rv_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_s;
  assign bus.fma_valid = fv_q;
  assign bus.fma_f0    = f0_q;
  assign bus.fma_f1    = f1_q;
  assign bus.fma_acc   = acc_q;
  assign bus.fma_tag   = tag_q;
  assign bus.res_valid = rv_q;
  assign bus.res       = res_q;

`ifdef FMA_SEQ_STICKY_INF_EN
  logic inf_q, inf_d;

  // Sticky OR of the infinity flag over every result of the current operation.
  always_comb begin
    inf_d = inf_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      inf_d = 1'b0;
    end else if (bus.fma_res_valid && bus.fma_inf) begin
      inf_d = 1'b1;
    end else begin
      inf_d = inf_q;
    end
  end

  // Sticky infinity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inf_q <= 1'b0;
    end else begin
      inf_q <= inf_d;
    end
  end

  assign bus.res_inf = inf_q;
`else
  logic unused_inf_s;
  assign unused_inf_s = bus.fma_inf;
  assign bus.res_inf  = 1'b0;
`endif
endmodule

// File: doc/fma_dot_sequencer.md
# fma_dot_sequencer

Sequencer that time-shares one pipelined FMA datapath (out = f0 * f1 + acc, exponent alignment via the shift calculation stage) to compute a length-K dot product. It accepts a stream of operand pairs, spreads the running sum over FMA_LAT+1 partial accumulators to hide pipeline latency, drains the pipe, and serially reduces the partials to one result. It sits between the systolic-array operand feeders and the shared FMA unit.

## Interface
- FMA_LAT, 3: fixed FMA pipeline depth in cycles; slot count S = FMA_LAT+1
- LEN_W, 8: width of the element-count input
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a dot product (sampled in IDLE only)
- len  in  LEN_W  element count K, sampled with start; 0 allowed
- busy  out  1  high from cycle after accepted start until result handshake
- in_valid / in_ready  in / out  1  operand handshake
- in_a, in_b  in  float_t  operand pair
- fma_valid  out  1  request to FMA (registered)
- fma_f0, fma_f1, fma_acc  out  float_t  FMA operands (registered)
- fma_tag  out  $clog2(S)  slot index travelling with request
- fma_res_valid  in  1  FMA result strobe
- fma_res  in  float_t  FMA result
- fma_res_tag  in  $clog2(S)  slot index of result
- fma_inf  in  1  isInf flag of the returning result
- res_valid / res_ready  out / in  1  result handshake
- res  out  float_t  dot product
- res_inf  out  1  infinity indication (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN, REDUCE, DONE.
- IDLE: start=1 → clear all S partials to +0, clear in-flight bits, issue count=0, slot ptr=0; go ISSUE, or DONE directly with res=+0 if len=0.
- ISSUE: in_ready = in-flight[ptr]==0. On handshake: next cycle fma_valid=1, f0=in_a, f1=in_b, acc=partial[ptr], tag=ptr; set in-flight[ptr]; ptr wraps S-1→0; count++. When count reaches K → DRAIN.
- Any state: fma_res_valid=1 → partial[fma_res_tag]=fma_res, clear in-flight[tag]. Result write and new issue to same slot in one cycle: write wins, issue is blocked by in_ready (never occurs with ready rule).
- DRAIN: wait until all in-flight bits clear → REDUCE with total=partial[0], j=1.
- REDUCE: for j=1..S-1 serially issue f0=partial[j], f1=ONE, acc=total (ONE = sign 0, exponent EXP_BIAS, mantissa 0), tag=0; wait for result, total=fma_res, j++. After j=S-1 result → DONE.
- DONE: res_valid=1, res=total held stable until res_ready=1 → IDLE, busy=0.
- start outside IDLE ignored. in_ready=0 outside ISSUE.
- Count compares at LEN_W bits; ptr is mod-S counter, S need not be power of two.

## Timing
- Reset values: busy=0, in_ready=0, fma_valid=0, fma_f0/f1/acc=0, fma_tag=0, res_valid=0, res=0, res_inf=0; state IDLE.
- Handshake → fma_valid: 1 cycle. fma_valid is a single-cycle pulse per request.
- With fixed FMA_LAT and continuous in_valid, in_ready never drops: K operands in K cycles.
- Reduction: S-1 round trips of FMA_LAT+1 cycles each.
- res_valid held until res_ready; res_ready without res_valid ignored.
- rst_n low at any time (incl. mid-ISSUE/REDUCE): immediate abort to reset values; late FMA results after reset release are not a concern of this block (FMA reset by same rst_n).

## Configuration
- FMA_SEQ_STICKY_INF_EN defined: res_inf = OR of fma_inf over every result of the current operation (issue and reduce), cleared on accepted start; valid with res_valid.
- Undefined: res_inf tied 0, no sticky register; fma_inf unused.

## Test plan
- FMA_LAT=3, K=4, a=(1,2,3,4), b=(1,1,1,1), continuous valid → in_ready high 4 cycles, res=10.0, res_valid held until res_ready.
- K=0 with start → DONE next cycle, res=+0, no fma_valid pulses.
- K=9, model FMA with latency 5 (> FMA_LAT) → in_ready deasserts when ptr slot in flight, no slot overwrite, res equals exact sum (a_i=b_i=1 → 9.0).
- start asserted during ISSUE and DONE → ignored, result of first operation unchanged.
- rst_n pulsed mid-REDUCE → all outputs to reset values within same cycle, next start K=2 a=(2,3) b=(2,2) → res=10.0.
- FMA_SEQ_STICKY_INF_EN: one operand exponent all-ones, fma_inf=1 on one result → res_inf=1; without macro → res_inf=0.
